// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared forward-select encodings for the pipeline hazard logic
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   typedef logic [1:0] fwd_t;

   localparam fwd_t FWD_RF    = 2'b00;
   localparam fwd_t FWD_IMM   = 2'b01;
   localparam fwd_t FWD_EXMEM = 2'b10;
   localparam fwd_t FWD_WB    = 2'b11;

   // Flag bits carried by each shadow slot alongside the register address.
   localparam int SLOT_FLAG_W = 3;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// fwd_sel : per-source producer match, forward select and load-use hazard
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_sel
   import pipe_pkg::*;
#(
   parameter int REG_AW       = 3,
   parameter int HAS_ZERO_REG = 1,
   parameter int LU_BUBBLES   = 1
) (
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   input  logic              ex_vld,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wr,
   input  logic              ex_ld,
   input  logic              mem_vld,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_wr,
   input  logic              mem_ld,
   output fwd_t              sel,
   output logic              hazard
);

   logic src_ok;
   logic ex_match;
   logic mem_match;

   assign src_ok    = use_src & ~((HAS_ZERO_REG != 0) && (src == '0));
   assign ex_match  = src_ok & ex_vld  & ex_wr  & (src == ex_rd);
   assign mem_match = src_ok & mem_vld & mem_wr & (src == mem_rd);

   // Load data is only available from WB, so a load one slot ahead always
   // stalls; with two bubbles a load two slots ahead stalls as well.
   assign hazard = (ex_match & ex_ld) | ((LU_BUBBLES == 2) && (mem_match & mem_ld));

   // Youngest producer wins: EX slot is checked before MEM slot.
   always_comb begin
      sel = FWD_RF;
      if (ex_match && !ex_ld) begin
         sel = FWD_EXMEM;
      end else if (mem_match && (!mem_ld || (LU_BUBBLES == 1))) begin
         sel = FWD_WB;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
// ============================================================================
// hazard_forward_ctrl : shadow pipeline of writers, load-use stall and
// registered forward selects for the EX stage. Rev 1.0
// ============================================================================
`default_nettype none

module hazard_forward_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW       = 3,
   parameter int HAS_ZERO_REG = 1,
   parameter int LU_BUBBLES   = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs_a,
   input  logic [REG_AW-1:0] id_rs_b,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic              id_use_st,
   input  logic              id_imm,
   input  logic              id_wr_en,
   input  logic              id_is_load,
   input  logic              ex_flush,
   output logic              stall,
   output logic              bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        fwd_st,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
   } slot_t;

   localparam int SLOT_W = REG_AW + SLOT_FLAG_W;
   localparam slot_t SLOT_NONE = slot_t'({SLOT_W{1'b0}});

   // Writers that have reached WB are seen through the write-first regfile,
   // so only the EX and MEM slots are tracked.
   slot_t ex_slot;
   slot_t mem_slot;

   logic [REG_AW-1:0] src     [3];
   logic              use_src [3];
   fwd_t              sel     [3];
   logic [2:0]        hazard;
   logic              issue;

   assign src[0]     = id_rs_a;
   assign src[1]     = id_rs_b;
   assign src[2]     = id_rd;
   assign use_src[0] = id_use_a;
   assign use_src[1] = id_use_b;
   assign use_src[2] = id_use_st;

   for (genvar i = 0; i < 3; i++) begin : g_src
      fwd_sel #(
         .REG_AW      (REG_AW),
         .HAS_ZERO_REG(HAS_ZERO_REG),
         .LU_BUBBLES  (LU_BUBBLES)
      ) u_fwd_sel (
         .src    (src[i]),
         .use_src(use_src[i]),
         .ex_vld (ex_slot.vld),
         .ex_rd  (ex_slot.rd),
         .ex_wr  (ex_slot.wr),
         .ex_ld  (ex_slot.ld),
         .mem_vld(mem_slot.vld),
         .mem_rd (mem_slot.rd),
         .mem_wr (mem_slot.wr),
         .mem_ld (mem_slot.ld),
         .sel    (sel[i]),
         .hazard (hazard[i])
      );
   end

   // Flush overrides stall: the instruction in ID is dead anyway.
   assign stall  = id_valid & ~ex_flush & (|hazard);
   assign bubble = stall | ex_flush;
   assign issue  = id_valid & ~stall & ~ex_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot   <= SLOT_NONE;
         mem_slot  <= SLOT_NONE;
         fwd_a     <= FWD_RF;
         fwd_b     <= FWD_RF;
         fwd_st    <= FWD_RF;
         stall_cnt <= '0;
      end else begin
         mem_slot <= ex_slot;
         if (issue) begin
            ex_slot <= '{vld: 1'b1, rd: id_rd, wr: id_wr_en, ld: id_is_load};
         end else begin
            ex_slot <= SLOT_NONE;
         end

         if (bubble || !id_valid) begin
            fwd_a  <= FWD_RF;
            fwd_b  <= FWD_RF;
            fwd_st <= FWD_RF;
         end else begin
            fwd_a  <= sel[0];
            fwd_b  <= id_imm ? FWD_IMM : sel[1];
            fwd_st <= sel[2];
         end

         if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
// ============================================================================
// tb_hazard_forward_ctrl : two instances (one and two load-use bubbles) driven
// by the same instruction stream, checked against a distance-based model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_forward_ctrl;

   localparam int AW = 3;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          id_valid = 1'b0;
   logic [AW-1:0] id_rs_a = '0, id_rs_b = '0, id_rd = '0;
   logic          id_use_a = 1'b0, id_use_b = 1'b0, id_use_st = 1'b0, id_imm = 1'b0;
   logic          id_wr_en = 1'b0, id_is_load = 1'b0, ex_flush = 1'b0;

   logic [1:0]          stall_o, bubble_o;
   logic [1:0][1:0]     fa, fb, fs;
   logic [1:0][CW-1:0]  cnt;

   hazard_forward_ctrl #(.REG_AW(AW), .HAS_ZERO_REG(1), .LU_BUBBLES(1), .CNT_W(CW)) u_lu1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
      .id_rd(id_rd), .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_st(id_use_st),
      .id_imm(id_imm), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_flush(ex_flush),
      .stall(stall_o[0]), .bubble(bubble_o[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .fwd_st(fs[0]),
      .stall_cnt(cnt[0]));

   hazard_forward_ctrl #(.REG_AW(AW), .HAS_ZERO_REG(1), .LU_BUBBLES(2), .CNT_W(CW)) u_lu2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
      .id_rd(id_rd), .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_st(id_use_st),
      .id_imm(id_imm), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .ex_flush(ex_flush),
      .stall(stall_o[1]), .bubble(bubble_o[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .fwd_st(fs[1]),
      .stall_cnt(cnt[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: the last two issued instructions per instance, index 0 = one
   // cycle older than ID, index 1 = two cycles older.
   typedef struct {
      bit vld;
      int rd;
      bit wr;
      bit ld;
   } slot_t;

   slot_t      hist [2][2];
   logic [1:0] m_fa [2] = '{2'b00, 2'b00};
   logic [1:0] m_fb [2] = '{2'b00, 2'b00};
   logic [1:0] m_fs [2] = '{2'b00, 2'b00};
   int         m_cnt[2] = '{0, 0};

   // Instance k has k+1 load-use bubbles: a load at distance d <= k+1 stalls.
   function automatic void src_eval(input int k, input int src, input bit used,
                                    output bit haz, output logic [1:0] sel);
      bit found = 1'b0;
      haz = 1'b0;
      sel = 2'b00;
      if (used && src != 0) begin
         for (int d = 0; d < 2; d++) begin
            if (hist[k][d].vld && hist[k][d].wr && hist[k][d].rd == src) begin
               if (hist[k][d].ld && d <= k) haz = 1'b1;
               if (!found) begin
                  found = 1'b1;
                  sel = (d == 0) ? 2'b10 : 2'b11;
               end
            end
         end
      end
   endfunction

   always @(negedge clk) begin : compare
      bit ha, hb, hs, est, ebb;
      logic [1:0] sa, sb, ss;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int d = 0; d < 2; d++) hist[k][d] = '{vld: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
            m_fa[k] = 2'b00; m_fb[k] = 2'b00; m_fs[k] = 2'b00; m_cnt[k] = 0;
         end
         src_eval(k, int'(id_rs_a), id_use_a, ha, sa);
         src_eval(k, int'(id_rs_b), id_use_b, hb, sb);
         src_eval(k, int'(id_rd), id_use_st, hs, ss);
         est = id_valid && !ex_flush && (ha || hb || hs);
         ebb = est || ex_flush;
         chk($sformatf("lu%0d.stall", k+1),  stall_o[k],  est);
         chk($sformatf("lu%0d.bubble", k+1), bubble_o[k], ebb);
         chk($sformatf("lu%0d.fwd_a", k+1),  fa[k],  m_fa[k]);
         chk($sformatf("lu%0d.fwd_b", k+1),  fb[k],  m_fb[k]);
         chk($sformatf("lu%0d.fwd_st", k+1), fs[k],  m_fs[k]);
         chk($sformatf("lu%0d.stall_cnt", k+1), cnt[k], m_cnt[k]);
         if (rst_n) begin
            if (ebb || !id_valid) begin
               m_fa[k] = 2'b00; m_fb[k] = 2'b00; m_fs[k] = 2'b00;
            end else begin
               m_fa[k] = sa;
               m_fb[k] = id_imm ? 2'b01 : sb;
               m_fs[k] = ss;
            end
            if (est && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            hist[k][1] = hist[k][0];
            if (id_valid && !est && !ex_flush)
               hist[k][0] = '{vld: 1'b1, rd: int'(id_rd), wr: id_wr_en, ld: id_is_load};
            else
               hist[k][0] = '{vld: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
         end
      end
   end

   task automatic set_ins(input bit v, input int rd, input int a, input int b, input bit ua,
                          input bit ub, input bit ust, input bit imm, input bit wr, input bit ld);
      id_valid = v; id_rd = AW'(rd); id_rs_a = AW'(a); id_rs_b = AW'(b);
      id_use_a = ua; id_use_b = ub; id_use_st = ust; id_imm = imm;
      id_wr_en = wr; id_is_load = ld;
   endtask

   task automatic alu(input int rd, input int a, input int b);
      set_ins(1, rd, a, b, 1, 1, 0, 0, 1, 0);
   endtask
   task automatic alui(input int rd, input int a, input int b);
      set_ins(1, rd, a, b, 1, 0, 0, 1, 1, 0);
   endtask
   task automatic lw(input int rd, input int a);
      set_ins(1, rd, a, 0, 1, 0, 0, 1, 1, 1);
   endtask
   task automatic sw(input int rt, input int a);
      set_ins(1, rt, a, 0, 1, 0, 1, 1, 0, 0);
   endtask
   task automatic nop();
      set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nop();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", stall_o[0], 0);
      chk("rst.fwd_a", fa[0], 0);
      chk("rst.cnt", cnt[1], 0);
      rst_n = 1'b1;

      // back-to-back ALU dependency forwards from EX/MEM
      alu(1, 2, 3); tick();
      alu(4, 1, 5); #1 chk("t1.stall", stall_o[0], 0); tick();
      chk("t1.lu1.fwd_a", fa[0], 2'b10);
      chk("t1.lu2.fwd_a", fa[1], 2'b10);

      // distance-two dependency forwards from WB; immediate overrides
      alu(1, 2, 3); tick(); nop(); tick();
      alu(6, 7, 1); tick();
      chk("t2.fwd_b", fb[0], 2'b11);
      alu(1, 2, 3); tick(); nop(); tick();
      alui(6, 7, 1); tick();
      chk("t2.imm.fwd_b", fb[0], 2'b01);

      // load-use: one stall with WB forwarding vs two stalls without
      nop(); tick(); tick();
      lw(2, 7); tick();
      alu(3, 2, 2); #1;
      chk("t3.lu1.stall", stall_o[0], 1);
      chk("t3.lu1.bubble", bubble_o[0], 1);
      chk("t3.lu2.stall", stall_o[1], 1);
      tick();
      chk("t3.lu1.stall2", stall_o[0], 0);
      chk("t3.lu2.stall2", stall_o[1], 1);
      tick();
      chk("t3.lu1.fwd_a", fa[0], 2'b11);
      chk("t3.lu1.fwd_b", fb[0], 2'b11);
      chk("t3.lu2.stall3", stall_o[1], 0);
      tick();
      chk("t3.lu2.fwd_a", fa[1], 2'b00);
      chk("t3.lu2.fwd_b", fb[1], 2'b00);

      // register zero never forwards or stalls
      nop(); tick(); tick();
      alu(0, 1, 2); tick();
      alu(1, 0, 0); #1 chk("t4.stall", stall_o[0], 0); tick();
      chk("t4.fwd_a", fa[0], 2'b00);
      chk("t4.fwd_b", fb[0], 2'b00);
      lw(0, 3); tick();
      alu(5, 0, 0); #1;
      chk("t4.lu1.stall", stall_o[0], 0);
      chk("t4.lu2.stall", stall_o[1], 0);
      tick();

      // store data: youngest writer wins; load feeding base and data
      nop(); tick(); tick();
      alu(4, 1, 2); tick();
      alu(4, 2, 3); tick();
      sw(4, 6); tick();
      chk("t5.fwd_st", fs[0], 2'b10);
      chk("t5.fwd_b", fb[0], 2'b01);
      nop(); tick(); tick();
      lw(5, 1); tick();
      sw(5, 5); #1 chk("t5.stall", stall_o[0], 1); tick();
      chk("t5.stall2", stall_o[0], 0); tick();
      chk("t5.fwd_a", fa[0], 2'b11);
      chk("t5.fwd_st", fs[0], 2'b11);
      nop(); tick(); tick(); tick();

      // flush during a load-use stall
      lw(2, 7); tick();
      alu(3, 2, 2); ex_flush = 1'b1; #1;
      chk("t6.flush.stall", stall_o[0], 0);
      chk("t6.flush.bubble", bubble_o[0], 1);
      tick();
      ex_flush = 1'b0; #1;
      chk("t6.after.lu1.stall", stall_o[0], 0);
      chk("t6.after.lu2.stall", stall_o[1], 1);
      tick();
      chk("t6.after.fwd_a", fa[0], 2'b11);
      nop(); tick(); tick(); tick();

      // asynchronous reset in the middle of a stall
      alu(7, 1, 1); tick();
      lw(2, 7); tick();
      alu(3, 2, 2); #1;
      chk("t6.pre.stall", stall_o[0], 1);
      chk("t6.pre.fwd_a", fa[0], 2'b10);
      rst_n = 1'b0; #1;
      chk("t6.rst.stall", stall_o[0], 0);
      chk("t6.rst.bubble", bubble_o[0], 0);
      chk("t6.rst.fwd_a", fa[0], 0);
      chk("t6.rst.cnt", cnt[0], 0);
      tick();
      rst_n = 1'b1; #1;
      chk("t6.release.stall", stall_o[0], 0);
      tick();

      // counter saturation after 2**CW+3 stalls
      repeat ((1 << CW) + 3) begin
         lw(2, 7); tick();
         alu(3, 2, 2); tick(); tick();
      end
      nop(); tick();
      chk("t6.sat.lu1", cnt[0], (1 << CW) - 1);
      chk("t6.sat.lu2", cnt[1], (1 << CW) - 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
